// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer_pkg
//  Description : Shared types and helpers for the switch debouncer: the
//                per-channel FSM state encoding, the default debounce
//                interval and the counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package switch_debouncer_pkg;

    // 10 ms at 100 MHz
    localparam int c_DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } debounceState_t;

    // Counter must hold values 0 .. cycles-1; sized for cycles+1 to keep a
    // width of at least 1 even when cycles == 1.
    function automatic int cntWidth(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : switch_debouncer_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One input channel: 2-flop synchroniser, debounce FSM with
//                stability counter, registered level/edge pulses and a
//                toggle latch that flips on every accepted rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cntWidth(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic rawIn,
    output logic cleanOut,
    output logic risePulse,
    output logic fallPulse,
    output logic toggleOut
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             r_syncMeta;
    logic             r_syncIn;
    debounceState_t   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;
    logic             r_toggle;

    debounceState_t   w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_cleanNext;
    logic             w_riseNext;
    logic             w_fallNext;
    logic             w_toggleNext;

    // Two-flop synchroniser for the asynchronous pin, nothing between stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_syncMeta <= 1'b0;
            r_syncIn   <= 1'b0;
        end else begin
            r_syncMeta <= rawIn;
            r_syncIn   <= r_syncMeta;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_LOW;
            r_cnt    <= '0;
            r_clean  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_clean  <= w_cleanNext;
            r_rise   <= w_riseNext;
            r_fall   <= w_fallNext;
            r_toggle <= w_toggleNext;
        end
    end

    // Next-state logic: a level is accepted only after it has been seen for
    // DEBOUNCE_CYCLES consecutive synchronised cycles; any reversal while
    // waiting drops back to the stable state silently.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = '0;
        w_cleanNext  = r_clean;
        w_riseNext   = 1'b0;
        w_fallNext   = 1'b0;
        w_toggleNext = r_toggle;
        case (r_state)
            ST_LOW: begin
                if (r_syncIn) begin
                    w_stateNext = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (!r_syncIn) begin
                    w_stateNext = ST_LOW;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_stateNext  = ST_HIGH;
                    w_cleanNext  = 1'b1;
                    w_riseNext   = 1'b1;
                    w_toggleNext = ~r_toggle;
                end else begin
                    w_cntNext = r_cnt + c_CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!r_syncIn) begin
                    w_stateNext = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (r_syncIn) begin
                    w_stateNext = ST_HIGH;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_stateNext = ST_LOW;
                    w_cleanNext = 1'b0;
                    w_fallNext  = 1'b1;
                end else begin
                    w_cntNext = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_stateNext = ST_LOW;
            end
        endcase
    end

    assign cleanOut  = r_clean;
    assign risePulse = r_rise;
    assign fallPulse = r_fall;
    assign toggleOut = r_toggle;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Input conditioner for slide switches and push buttons.
//                Replicates one independent debounce channel per input.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_INPUTS        = 2,
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] rawIn,
    output logic [N_INPUTS-1:0] cleanOut,
    output logic [N_INPUTS-1:0] risePulse,
    output logic [N_INPUTS-1:0] fallPulse,
    output logic [N_INPUTS-1:0] toggleOut
);

    localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES);

    // One fully independent channel per input pin
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .rawIn     (rawIn[i]),
            .cleanOut  (cleanOut[i]),
            .risePulse (risePulse[i]),
            .fallPulse (fallPulse[i]),
            .toggleOut (toggleOut[i])
        );
    end

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Scoreboard bench for switch_debouncer (DEBOUNCE_CYCLES = 4).
//                Each driven cycle queues the hand-computed outputs expected
//                after that clock edge; a monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_switch_debouncer;

    typedef struct packed {
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] tog;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] rawIn;
    logic [1:0] cleanOut;
    logic [1:0] risePulse;
    logic [1:0] fallPulse;
    logic [1:0] toggleOut;

    exp_t expQ[$];
    int   nTests;
    int   nFail;

    switch_debouncer #(
        .N_INPUTS        (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rawIn     (rawIn),
        .cleanOut  (cleanOut),
        .risePulse (risePulse),
        .fallPulse (fallPulse),
        .toggleOut (toggleOut)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [1:0] act,
                         input logic [1:0] exp, input int cyc);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Monitor: after each edge compare the outputs against the next entry
    initial begin
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("cleanOut",  cleanOut,  e.clean, cyc);
                check("risePulse", risePulse, e.rise,  cyc);
                check("fallPulse", fallPulse, e.fall,  cyc);
                check("toggleOut", toggleOut, e.tog,   cyc);
                cyc++;
            end
        end
    end

    // Drive n cycles of (r, raw) and queue the outputs expected after each edge
    task automatic drive(input logic r, input logic [1:0] raw,
                         input logic [1:0] c, input logic [1:0] ri,
                         input logic [1:0] f, input logic [1:0] t,
                         input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst   = r;
            rawIn = raw;
            expQ.push_back('{clean: c, rise: ri, fall: f, tog: t});
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int waitCycles;
        nTests = 0;
        nFail  = 0;
        rst    = 1'b1;
        rawIn  = 2'b11;

        // Reset held with both pins high, then first cycle after release
        drive(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);

        // Clean press on ch0: rise on edge 6
        drive(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6);
        drive(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1);
        drive(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 3);

        // Release ch0: fall on edge 6, toggle kept
        drive(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 6);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2);

        // Second press: toggle returns to 0, then release
        drive(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 6);
        drive(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        drive(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);
        drive(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);

        // Bounce on ch1: high 3, low 2, high 3, low -> nothing accepted
        drive(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        drive(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8);

        // Simultaneous press and release on both channels
        drive(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 6);
        drive(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 1);
        drive(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 1);
        drive(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 6);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1);
        drive(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1);

        // Reset mid-count on ch0 (rst at edge 3), pin held high afterwards
        drive(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 3);
        drive(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        drive(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6);
        drive(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1);
        drive(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2);

        // Let the monitor drain the scoreboard
        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire
